// File: rtl/zoom_pixel_fetch.sv
// Maps the 640x480 display raster onto a 320x240 framebuffer with 1x/2x/4x zoom and pan.
// Read address is issued one cycle after the raster sample. Colour, sync and de come out MEM_LATENCY+2 cycles after it.
module zoom_pixel_fetch #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk_25mhz,
    input  logic        rst,
    input  logic [15:0] h_value,
    input  logic [15:0] v_value,
    input  logic [1:0]  zoom_sel,
    input  logic [8:0]  pan_x,
    input  logic [7:0]  pan_y,
    output logic [16:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [11:0] mem_data,
    output logic        h_sync,
    output logic        v_sync,
    output logic        de,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    logic [1:0]             r_zoom;
    logic [8:0]             r_pan_x;
    logic [7:0]             r_pan_y;
    logic [16:0]            r_mem_addr;
    logic                   r_mem_rd_en;
    logic [MEM_LATENCY:0]   r_act_p;
    logic [MEM_LATENCY:0]   r_hs_p;
    logic [MEM_LATENCY:0]   r_vs_p;
    logic                   r_h_sync;
    logic                   r_v_sync;
    logic                   r_de;
    logic [11:0]            r_rgb;

    logic        w_frame_start;
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic [1:0]  w_zoom_nxt;
    logic [8:0]  w_pan_x_max;
    logic [7:0]  w_pan_y_max;
    logic [8:0]  w_pan_x_cl;
    logic [7:0]  w_pan_y_cl;
    logic [1:0]  w_shift;
    logic [9:0]  w_dx;
    logic [9:0]  w_dy;
    logic [9:0]  w_sx;
    logic [9:0]  w_sy;
    logic [16:0] w_sy17;
    logic [16:0] w_addr;

    assign w_frame_start = (h_value == 16'd0) && (v_value == 16'd0);
    assign w_active      = (h_value >= 16'd144) && (h_value <= 16'd783) &&
                           (v_value >= 16'd35)  && (v_value <= 16'd514);
    assign w_hs          = (h_value < 16'd96);
    assign w_vs          = (v_value < 16'd2);

    // The reserved zoom code keeps the current zoom, and the pan clamp uses that same zoom.
    assign w_zoom_nxt = (zoom_sel == 2'b11) ? r_zoom : zoom_sel;

    always_comb begin
        w_pan_x_max = 9'd240;
        w_pan_y_max = 8'd180;
        case (w_zoom_nxt)
            2'b00: begin
                w_pan_x_max = 9'd0;
                w_pan_y_max = 8'd0;
            end
            2'b01: begin
                w_pan_x_max = 9'd160;
                w_pan_y_max = 8'd120;
            end
            default: begin
                w_pan_x_max = 9'd240;
                w_pan_y_max = 8'd180;
            end
        endcase
    end

    assign w_pan_x_cl = (pan_x > w_pan_x_max) ? w_pan_x_max : pan_x;
    assign w_pan_y_cl = (pan_y > w_pan_y_max) ? w_pan_y_max : pan_y;

    // Zoom codes 00/01/10 map to shifts 1/2/3.
    assign w_shift = r_zoom + 2'd1;
    assign w_dx    = h_value[9:0] - 10'd144;
    assign w_dy    = v_value[9:0] - 10'd35;
    assign w_sx    = {1'b0, r_pan_x} + (w_dx >> w_shift);
    assign w_sy    = {2'b0, r_pan_y} + (w_dy >> w_shift);
    assign w_sy17  = {7'b0, w_sy};
    assign w_addr  = (w_sy17 << 8) + (w_sy17 << 6) + {7'b0, w_sx};

    always_ff @(posedge clk_25mhz) begin
        if (!rst) begin
            r_zoom      <= 2'b00;
            r_pan_x     <= '0;
            r_pan_y     <= '0;
            r_mem_addr  <= '0;
            r_mem_rd_en <= 1'b0;
            r_act_p     <= '0;
            r_hs_p      <= '0;
            r_vs_p      <= '0;
            r_h_sync    <= 1'b0;
            r_v_sync    <= 1'b0;
            r_de        <= 1'b0;
            r_rgb       <= '0;
        end else begin
            if (w_frame_start) begin
                r_zoom  <= w_zoom_nxt;
                r_pan_x <= w_pan_x_cl;
                r_pan_y <= w_pan_y_cl;
            end
            r_mem_rd_en <= w_active;
            if (w_active) begin
                r_mem_addr <= w_addr;
            end
            r_act_p  <= {r_act_p[MEM_LATENCY-1:0], w_active};
            r_hs_p   <= {r_hs_p[MEM_LATENCY-1:0], w_hs};
            r_vs_p   <= {r_vs_p[MEM_LATENCY-1:0], w_vs};
            r_h_sync <= r_hs_p[MEM_LATENCY];
            r_v_sync <= r_vs_p[MEM_LATENCY];
            r_de     <= r_act_p[MEM_LATENCY];
            r_rgb    <= r_act_p[MEM_LATENCY] ? mem_data : 12'h000;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign h_sync    = r_h_sync;
    assign v_sync    = r_v_sync;
    assign de        = r_de;
    assign red       = r_rgb[11:8];
    assign green     = r_rgb[7:4];
    assign blue      = r_rgb[3:0];

endmodule

// File: tb/tb_zoom_pixel_fetch.sv
// Directed bench for zoom_pixel_fetch.
// Two instances are driven by the same raster: one with MEM_LATENCY=2 and one with MEM_LATENCY=3.
module tb_zoom_pixel_fetch;

    logic        clk_25mhz = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] h_value = 16'd0;
    logic [15:0] v_value = 16'd0;
    logic [1:0]  zoom_sel = 2'b00;
    logic [8:0]  pan_x = 9'd0;
    logic [7:0]  pan_y = 8'd0;

    logic [16:0] mem_addr2, mem_addr3;
    logic        rd2, rd3;
    logic [11:0] mem_data2, mem_data3;
    logic        hs2, hs3, vs2, vs3, de2, de3;
    logic [3:0]  r2, g2, b2, r3, g3, b3;

    int checks = 0;
    int errors = 0;

    always #20 clk_25mhz = ~clk_25mhz;

    zoom_pixel_fetch #(.MEM_LATENCY(2)) u_dut2 (
        .clk_25mhz(clk_25mhz), .rst(rst), .h_value(h_value), .v_value(v_value),
        .zoom_sel(zoom_sel), .pan_x(pan_x), .pan_y(pan_y),
        .mem_addr(mem_addr2), .mem_rd_en(rd2), .mem_data(mem_data2),
        .h_sync(hs2), .v_sync(vs2), .de(de2), .red(r2), .green(g2), .blue(b2)
    );

    zoom_pixel_fetch #(.MEM_LATENCY(3)) u_dut3 (
        .clk_25mhz(clk_25mhz), .rst(rst), .h_value(h_value), .v_value(v_value),
        .zoom_sel(zoom_sel), .pan_x(pan_x), .pan_y(pan_y),
        .mem_addr(mem_addr3), .mem_rd_en(rd3), .mem_data(mem_data3),
        .h_sync(hs3), .v_sync(vs3), .de(de3), .red(r3), .green(g3), .blue(b3)
    );

    // Framebuffer model: word at address a is (a*7 + 0xABC) mod 4096, so address 0 reads 0xABC.
    function automatic logic [11:0] mem_f(input logic [16:0] a);
        logic [16:0] t;
        t = a * 17'd7 + 17'hABC;
        return t[11:0];
    endfunction

    logic [16:0] d2_0 = '0, d2_1 = '0;
    logic [16:0] d3_0 = '0, d3_1 = '0, d3_2 = '0;
    always @(posedge clk_25mhz) begin
        d2_0 <= mem_addr2;
        d2_1 <= d2_0;
        d3_0 <= mem_addr3;
        d3_1 <= d3_0;
        d3_2 <= d3_1;
    end
    assign mem_data2 = mem_f(d2_1);
    assign mem_data3 = mem_f(d3_2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic sample(input logic [15:0] h, input logic [15:0] v);
        h_value = h;
        v_value = v;
        tick();
    endtask

    task automatic idle();
        sample(16'd120, 16'd300);
    endtask

    task automatic frame_start(input logic [1:0] z, input logic [8:0] px, input logic [7:0] py);
        zoom_sel = z;
        pan_x    = px;
        pan_y    = py;
        sample(16'd0, 16'd0);
        h_value  = 16'd120;
        v_value  = 16'd300;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_addr2"}, 32'(mem_addr2), 32'd0);
        chk({tag, "_rd2"},   32'(rd2), 32'd0);
        chk({tag, "_sync2"}, 32'({hs2, vs2, de2}), 32'd0);
        chk({tag, "_rgb2"},  32'({r2, g2, b2}), 32'd0);
        chk({tag, "_addr3"}, 32'(mem_addr3), 32'd0);
        chk({tag, "_rd3"},   32'(rd3), 32'd0);
        chk({tag, "_sync3"}, 32'({hs3, vs3, de3}), 32'd0);
        chk({tag, "_rgb3"},  32'({r3, g3, b3}), 32'd0);
    endtask

    initial begin
        // Reset held for 3 cycles with active, frame-start and sync inputs.
        rst = 1'b0;
        zoom_sel = 2'b10;
        pan_x = 9'd100;
        pan_y = 8'd50;
        sample(16'd144, 16'd35);
        chk_idle("rst0");
        sample(16'd0, 16'd0);
        chk_idle("rst1");
        sample(16'd50, 16'd0);
        chk_idle("rst2");
        rst = 1'b1;
        zoom_sel = 2'b00;
        pan_x = 9'd0;
        pan_y = 8'd0;
        idle();
        chk_idle("rst_after");

        // Reset defaults: 1x, pan (0,0).
        sample(16'd144, 16'd35);
        chk("x1_addr0", 32'(mem_addr2), 32'd0);
        chk("x1_rd0",   32'(rd2), 32'd1);
        sample(16'd146, 16'd35);
        chk("x1_addr1", 32'(mem_addr2), 32'd1);
        sample(16'd144, 16'd37);
        chk("x1_addr320", 32'(mem_addr2), 32'd320);
        chk("x1_de_early", 32'(de2), 32'd0);
        idle();
        chk("x1_rgb0", 32'({r2, g2, b2}), 32'hABC);
        chk("x1_de0", 32'(de2), 32'd1);
        chk("x1_rd_off", 32'(rd2), 32'd0);
        chk("x1_addr_hold", 32'(mem_addr2), 32'd320);
        chk("l3_de_early", 32'(de3), 32'd0);
        idle();
        chk("x1_rgb1", 32'({r2, g2, b2}), 32'hAC3);
        chk("l3_rgb0", 32'({r3, g3, b3}), 32'hABC);
        chk("l3_de0", 32'(de3), 32'd1);
        idle();
        chk("x1_rgb320", 32'({r2, g2, b2}), 32'h37C);
        idle();
        chk("x1_de_off", 32'(de2), 32'd0);
        chk("x1_rgb_off", 32'({r2, g2, b2}), 32'd0);

        // 4x, pan (100,50); input changes after frame start are ignored.
        frame_start(2'b10, 9'd100, 8'd50);
        zoom_sel = 2'b00;
        pan_x = 9'd0;
        pan_y = 8'd0;
        sample(16'd160, 16'd35);
        chk("x4_addr_a", 32'(mem_addr2), 32'd16102);
        sample(16'd160, 16'd43);
        chk("x4_addr_b", 32'(mem_addr2), 32'd16422);

        // Pan clamping at 4x and 2x, and the bottom-right corner.
        frame_start(2'b10, 9'd300, 8'd200);
        sample(16'd144, 16'd35);
        chk("clamp4_tl", 32'(mem_addr2), 32'd57840);
        sample(16'd783, 16'd514);
        chk("clamp4_br", 32'(mem_addr2), 32'd76799);
        frame_start(2'b01, 9'd300, 8'd200);
        sample(16'd144, 16'd35);
        chk("clamp2_tl", 32'(mem_addr2), 32'd38560);
        sample(16'd783, 16'd514);
        chk("clamp2_br", 32'(mem_addr2), 32'd76799);

        // A zoom change mid-frame waits for the next frame start; the reserved code keeps 4x.
        frame_start(2'b00, 9'd0, 8'd0);
        zoom_sel = 2'b10;
        sample(16'd200, 16'd200);
        chk("mid_x1_a", 32'(mem_addr2), 32'd26268);
        sample(16'd300, 16'd200);
        chk("mid_x1_b", 32'(mem_addr2), 32'd26318);
        frame_start(2'b10, 9'd0, 8'd0);
        sample(16'd200, 16'd200);
        chk("mid_x4", 32'(mem_addr2), 32'd6407);
        frame_start(2'b11, 9'd0, 8'd0);
        sample(16'd200, 16'd200);
        chk("rsvd_x4", 32'(mem_addr2), 32'd6407);

        // Reset wins over frame-start sampling on the same edge.
        zoom_sel = 2'b10;
        pan_x = 9'd100;
        pan_y = 8'd50;
        rst = 1'b0;
        sample(16'd0, 16'd0);
        rst = 1'b1;
        sample(16'd200, 16'd200);
        chk("rst_fs_addr", 32'(mem_addr2), 32'd26268);
        idle();
        idle();
        chk("rst_fs_de_early", 32'(de2), 32'd0);
        idle();
        chk("rst_fs_de", 32'(de2), 32'd1);
        chk("rst_fs_rgb", 32'({r2, g2, b2}), 32'h900);

        // Blanking with both syncs asserted; check alignment at both latencies.
        sample(16'd50, 16'd0);
        chk("blank_rd2", 32'(rd2), 32'd0);
        chk("blank_rd3", 32'(rd3), 32'd0);
        idle();
        idle();
        chk("blank_hs2_early", 32'(hs2), 32'd0);
        idle();
        chk("blank_sync2", 32'({hs2, vs2, de2}), 32'b110);
        chk("blank_rgb2", 32'({r2, g2, b2}), 32'd0);
        chk("blank_hs3_early", 32'(hs3), 32'd0);
        idle();
        chk("blank_sync3", 32'({hs3, vs3, de3}), 32'b110);
        chk("blank_rgb3", 32'({r3, g3, b3}), 32'd0);
        chk("blank_hs2_late", 32'(hs2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
